// File: rtl/instr_types_pkg.sv
// Shared rename/commit types and sizing for the physical register file.
package instr_types_pkg;

   localparam int unsigned NUM_PHYS_REGS   = 64;
   localparam int unsigned NUM_ARCH_REGS   = 32;
   localparam int unsigned MAP_TABLE_DEPTH = 4;
   localparam int unsigned FREE_LIST_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;

   localparam int unsigned PHYS_REG_TAG_W   = $clog2(NUM_PHYS_REGS);
   localparam int unsigned MAP_TABLE_COL_W  = $clog2(MAP_TABLE_DEPTH);
   localparam int unsigned FREE_LIST_IDX_W  = $clog2(FREE_LIST_DEPTH);
   localparam int unsigned FREE_LIST_PTR_W  = FREE_LIST_IDX_W + 1;

   typedef logic [PHYS_REG_TAG_W-1:0]  phys_reg_tag_t;
   typedef logic [MAP_TABLE_COL_W-1:0] map_table_column_index_t;
   // Extra MSB is the wrap bit so full and empty are distinguishable.
   typedef logic [FREE_LIST_PTR_W-1:0] free_list_ptr_t;
   typedef logic [FREE_LIST_IDX_W-1:0] free_list_idx_t;

endpackage

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register tags with per-column head checkpoints
// so a mispredict restore reclaims every tag allocated since the branch.
module phys_reg_free_list
   import instr_types_pkg::*;
(
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       dequeue_valid,
   output logic                       dequeue_success,
   output logic [PHYS_REG_TAG_W-1:0]  dequeue_phys_reg_tag,
   input  logic                       commit_free_valid,
   input  logic [PHYS_REG_TAG_W-1:0]  commit_free_phys_reg_tag,
   input  logic                       revert_valid,
   input  logic [PHYS_REG_TAG_W-1:0]  revert_speculated_phys_reg_tag,
   input  logic                       save_checkpoint_valid,
   input  logic [MAP_TABLE_COL_W-1:0] save_checkpoint_column,
   input  logic                       restore_checkpoint_valid,
   input  logic                       restore_checkpoint_speculate_failed,
   input  logic [MAP_TABLE_COL_W-1:0] restore_checkpoint_column,
   output logic [FREE_LIST_PTR_W-1:0] free_count,
   output logic                       empty
);

   localparam free_list_ptr_t DEPTH_PTR = free_list_ptr_t'(FREE_LIST_DEPTH);

   phys_reg_tag_t  entries   [FREE_LIST_DEPTH];
   free_list_ptr_t ckpt_head [MAP_TABLE_DEPTH];
   free_list_ptr_t head, tail, head_next, head_m1, count;
   logic           full, ckpt_we;

   assign count   = tail - head;
   assign full    = (count == DEPTH_PTR);
   assign head_m1 = head - free_list_ptr_t'(1);

   assign free_count           = count;
   assign empty                = (count == '0);
   assign dequeue_phys_reg_tag = entries[free_list_idx_t'(head)];

   // Head side: one action per cycle, revert > restore > save > dequeue.
   always_comb begin
      head_next       = head;
      dequeue_success = 1'b0;
      ckpt_we         = 1'b0;
      if (revert_valid) begin
         head_next = head_m1;
      end else if (restore_checkpoint_valid) begin
         if (restore_checkpoint_speculate_failed)
            head_next = ckpt_head[restore_checkpoint_column];
      end else if (save_checkpoint_valid) begin
         ckpt_we = 1'b1;
      end else if (dequeue_valid && !empty) begin
         dequeue_success = 1'b1;
         head_next       = head + free_list_ptr_t'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head <= '0;
         for (int unsigned i = 0; i < MAP_TABLE_DEPTH; i++)
            ckpt_head[i] <= '0;
      end else begin
         head <= head_next;
         if (ckpt_we)
            ckpt_head[save_checkpoint_column] <= head;
      end
   end

   // Tail side runs independently of the head-side priority chain.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tail <= DEPTH_PTR;
         for (int unsigned i = 0; i < FREE_LIST_DEPTH; i++)
            entries[i] <= phys_reg_tag_t'(NUM_ARCH_REGS + i);
      end else if (commit_free_valid && !full) begin
         entries[free_list_idx_t'(tail)] <= commit_free_phys_reg_tag;
         tail                            <= tail + free_list_ptr_t'(1);
      end
   end

   always @(posedge CLK) begin
      if (!RST) begin
         if (revert_valid)
            assert (entries[free_list_idx_t'(head_m1)] == revert_speculated_phys_reg_tag
                    && count < DEPTH_PTR);
         if (commit_free_valid)
            assert (!full);
         if (!revert_valid && restore_checkpoint_valid && restore_checkpoint_speculate_failed)
            assert (free_list_ptr_t'(tail - ckpt_head[restore_checkpoint_column]) <= DEPTH_PTR);
      end
   end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
Supplies free physical register tags to rename: the new dest tag for each rename written into phys_reg_map_table. Reclaims tags from commit (old safe mapping freed) and from revert (speculated mapping undone). Circular FIFO of tags whose head pointer is checkpointed per map-table column, so a failed-speculation restore reclaims every tag allocated since the checkpoint in one cycle. Sits in the core next to phys_reg_map_table and is driven by the same dispatch/ROB control.

Parameters:
NUM_PHYS_REGS, 64, total physical registers (from package)
NUM_ARCH_REGS, 32, architectural registers (from package)
FREE_LIST_DEPTH, NUM_PHYS_REGS-NUM_ARCH_REGS = 32, FIFO entries
MAP_TABLE_DEPTH, 4, checkpoint slots; one per map-table column

Ports:
CLK  in  1  clock
RST  in  1  reset; one clock, reset asynchronous and active-high
dequeue_valid  in  1  rename requests a new dest tag
dequeue_success  out  1  tag granted this cycle
dequeue_phys_reg_tag  out  phys_reg_tag_t (6)  tag at head
commit_free_valid  in  1  commit returns old safe tag
commit_free_phys_reg_tag  in  phys_reg_tag_t (6)  tag to free
revert_valid  in  1  revert walk undoes one rename, youngest first
revert_speculated_phys_reg_tag  in  phys_reg_tag_t (6)  tag being un-allocated
save_checkpoint_valid  in  1  branch checkpoint
save_checkpoint_column  in  map_table_column_index_t (2)  slot to write
restore_checkpoint_valid  in  1  branch resolved
restore_checkpoint_speculate_failed  in  1  1 = mispredict, restore head
restore_checkpoint_column  in  map_table_column_index_t (2)  slot to read
free_count  out  6  entries held, 0..32
empty  out  1  free_count == 0

Behaviour:
- Storage: FREE_LIST_DEPTH x phys_reg_tag_t; head/tail pointers of log2(DEPTH)+1 bits (MSB = wrap bit); count = tail - head modulo 2^(log2+1).
- Reset (async, RST=1): entry[i] = NUM_ARCH_REGS+i; head = 0; tail = 6'b100000 (full); all checkpoint heads = 0. Outputs after reset with inputs low: dequeue_success=0, dequeue_phys_reg_tag=32, free_count=32, empty=0.
- Read is zero-latency: dequeue_phys_reg_tag = entry[head idx] combinationally, also when empty (value don't-care).
- Head-side priority per cycle, only one taken: revert > restore > save > dequeue.
  - revert_valid: head <= head-1. Assert entry[head-1] == revert_speculated_phys_reg_tag and count < DEPTH. dequeue_success=0.
  - restore_checkpoint_valid & speculate_failed: head <= ckpt_head[restore_checkpoint_column]; dequeue_success=0.
  - restore_checkpoint_valid & ~speculate_failed: no pointer change; dequeue_success=0 this cycle.
  - save_checkpoint_valid: ckpt_head[save_checkpoint_column] <= head (pre-dequeue value); dequeue ignored, dequeue_success=0.
  - dequeue_valid & ~empty: dequeue_success=1, head <= head+1. If empty: dequeue_success=0, no change.
- Tail side is independent and takes effect every cycle: commit_free_valid writes entry[tail idx] and tail <= tail+1. Enqueue while count == DEPTH (pre-state): assert, drop write.
- Same-cycle dequeue + commit: both act. Empty pre-state: the freed tag is not bypassed; dequeue_success=0.
- Same-cycle restore/revert + commit: head and tail both update. Restore guarantees tail - ckpt_head <= DEPTH, so un-dequeued slots are never overwritten. Assert this.
- Pointer arithmetic wraps modulo 2^(log2(DEPTH)+1). Index = low log2(DEPTH) bits.
- free_count and empty are derived from registered pointers (current state).

Decomposition:
- In instr_types_pkg: phys_reg_tag_t, map_table_column_index_t, NUM_PHYS_REGS, NUM_ARCH_REGS, MAP_TABLE_DEPTH, and new FREE_LIST_DEPTH and free_list_ptr_t (log2(DEPTH)+1 bits).
- Single module with no sub-module. Checkpoint head array is a small inline register file.

Test Plan:
- Reset then dequeue_valid for 3 cycles -> tags 32, 33, 34 with success=1; free_count=29.
- Drain all 32 -> empty=1; next dequeue_valid -> success=0. Same cycle commit_free tag 7 -> next cycle empty=0, dequeue returns 7.
- Wrap: drain 32, commit-free tags 40..63 then 32..39 -> dequeues return that order; pointers wrap and count is correct.
- save_checkpoint column 2 at head=3 (dequeue ignored that cycle); dequeue 35..38; restore failed column 2 -> head=3, next dequeue returns 35, free_count +4.
- After dequeuing 32, 33: revert with 33, then revert with 32 -> head=0, count=32. Revert with wrong tag fires the assertion.
- restore with speculate_failed=0 together with dequeue_valid -> no head change, success=0. Next cycle dequeue succeeds normally.
